// File: rtl/operand_fwd_unit_pkg.sv
// operand_fwd_unit_pkg
//   Shared pipeline constants for the decode-stage operand forwarding unit:
//   the "no register" ID, forward-source indices and the load-use FSM states.
package operand_fwd_unit_pkg;

  localparam logic [3:0] RNONE_DEF = 4'hF;

  // Forward sources in priority order; index doubles as the fwd_cnt slot.
  localparam int unsigned NSRC      = 5;
  localparam int unsigned SRC_IDX_W = 3;
  localparam logic [SRC_IDX_W-1:0] SRC_E_VALE = 3'd0;
  localparam logic [SRC_IDX_W-1:0] SRC_M_VALM = 3'd1;
  localparam logic [SRC_IDX_W-1:0] SRC_M_VALE = 3'd2;
  localparam logic [SRC_IDX_W-1:0] SRC_W_VALM = 3'd3;
  localparam logic [SRC_IDX_W-1:0] SRC_W_VALE = 3'd4;
  localparam logic [SRC_IDX_W-1:0] SRC_RF     = 3'd5;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/operand_fwd_unit_fwd_port_mux.sv
// fwd_port_mux
//   Single read-port priority selector. Picks the youngest in-flight result
//   whose destination matches the port's source register, else the register
//   file value, and reports which source was chosen.
// Ports:
//   src_i              source register ID of this port
//   rval_i             register-file read data
//   e_dstE_i/e_valE_i  execute ALU result
//   M_dstM_i/m_valM_i  memory-stage load result
//   M_dstE_i/M_valE_i  memory-stage ALU result
//   W_dstM_i/W_valM_i  write-back load result
//   W_dstE_i/W_valE_i  write-back ALU result
//   val_o              forwarded operand
//   sel_o              chosen source index (SRC_RF when not forwarded)
module fwd_port_mux
  import operand_fwd_unit_pkg::*;
#(
  parameter int unsigned          DATA_W = 64,
  parameter int unsigned          REG_W  = 4,
  parameter logic [REG_W-1:0]     RNONE  = RNONE_DEF
) (
  input  logic [REG_W-1:0]     src_i,
  input  logic [DATA_W-1:0]    rval_i,
  input  logic [REG_W-1:0]     e_dstE_i,
  input  logic [DATA_W-1:0]    e_valE_i,
  input  logic [REG_W-1:0]     M_dstM_i,
  input  logic [DATA_W-1:0]    m_valM_i,
  input  logic [REG_W-1:0]     M_dstE_i,
  input  logic [DATA_W-1:0]    M_valE_i,
  input  logic [REG_W-1:0]     W_dstM_i,
  input  logic [DATA_W-1:0]    W_valM_i,
  input  logic [REG_W-1:0]     W_dstE_i,
  input  logic [DATA_W-1:0]    W_valE_i,
  output logic [DATA_W-1:0]    val_o,
  output logic [SRC_IDX_W-1:0] sel_o
);

  // Gating on src != RNONE also excludes RNONE destinations, since any
  // match then implies the destination is a real register.
  always_comb begin
    val_o = rval_i;
    sel_o = SRC_RF;
    if (src_i != RNONE) begin
      if (src_i == e_dstE_i) begin
        val_o = e_valE_i;
        sel_o = SRC_E_VALE;
      end else if (src_i == M_dstM_i) begin
        val_o = m_valM_i;
        sel_o = SRC_M_VALM;
      end else if (src_i == M_dstE_i) begin
        val_o = M_valE_i;
        sel_o = SRC_M_VALE;
      end else if (src_i == W_dstM_i) begin
        val_o = W_valM_i;
        sel_o = SRC_W_VALM;
      end else if (src_i == W_dstE_i) begin
        val_o = W_valE_i;
        sel_o = SRC_W_VALE;
      end
    end
  end

endmodule

// File: rtl/operand_fwd_unit.sv
// operand_fwd_unit
//   Decode-stage operand forwarding with load-use stall detection, a
//   protocol checker (stall requested twice in a row) and saturating
//   forward/stall statistics.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   d_valid               decode holds a real instruction
//   d_src, d_rval         packed per-port source IDs and register-file data
//   e_dstE/e_valE         execute ALU result
//   E_dstM                destination of a load in execute (RNONE if none)
//   M_*/m_valM, W_*       memory and write-back results
//   cnt_clr               synchronous clear of all counters
//   d_val                 packed forwarded operands
//   lu_stall              load-use stall request
//   hazard_err            sticky stall-while-stalled flag
//   fwd_cnt, stall_cnt    saturating statistics
module operand_fwd_unit
  import operand_fwd_unit_pkg::*;
#(
  parameter int unsigned      NPORTS = 2,
  parameter int unsigned      DATA_W = 64,
  parameter int unsigned      REG_W  = 4,
  parameter logic [REG_W-1:0] RNONE  = RNONE_DEF,
  parameter int unsigned      CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       d_valid,
  input  logic [NPORTS*REG_W-1:0]    d_src,
  input  logic [NPORTS*DATA_W-1:0]   d_rval,
  input  logic [REG_W-1:0]           e_dstE,
  input  logic [DATA_W-1:0]          e_valE,
  input  logic [REG_W-1:0]           E_dstM,
  input  logic [REG_W-1:0]           M_dstE,
  input  logic [DATA_W-1:0]          M_valE,
  input  logic [REG_W-1:0]           M_dstM,
  input  logic [DATA_W-1:0]          m_valM,
  input  logic [REG_W-1:0]           W_dstE,
  input  logic [DATA_W-1:0]          W_valE,
  input  logic [REG_W-1:0]           W_dstM,
  input  logic [DATA_W-1:0]          W_valM,
  input  logic                       cnt_clr,
  output logic [NPORTS*DATA_W-1:0]   d_val,
  output logic                       lu_stall,
  output logic                       hazard_err,
  output logic [NSRC*CNT_W-1:0]      fwd_cnt,
  output logic [CNT_W-1:0]           stall_cnt
);

  logic [SRC_IDX_W-1:0] port_sel [NPORTS];

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    fwd_port_mux #(
      .DATA_W (DATA_W),
      .REG_W  (REG_W),
      .RNONE  (RNONE)
    ) u_mux (
      .src_i    (d_src[p*REG_W +: REG_W]),
      .rval_i   (d_rval[p*DATA_W +: DATA_W]),
      .e_dstE_i (e_dstE),
      .e_valE_i (e_valE),
      .M_dstM_i (M_dstM),
      .m_valM_i (m_valM),
      .M_dstE_i (M_dstE),
      .M_valE_i (M_valE),
      .W_dstM_i (W_dstM),
      .W_valM_i (W_valM),
      .W_dstE_i (W_dstE),
      .W_valE_i (W_valE),
      .val_o    (d_val[p*DATA_W +: DATA_W]),
      .sel_o    (port_sel[p])
    );
  end

  // E_dstM != RNONE already rules out an RNONE source matching.
  always_comb begin
    lu_stall = 1'b0;
    if (d_valid && (E_dstM != RNONE)) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (d_src[p*REG_W +: REG_W] == E_dstM) lu_stall = 1'b1;
      end
    end
  end

  // ---------------- load-use FSM ----------------
  fsm_state_e state_q, state_d;
  logic       hazard_q, hazard_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      hazard_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hazard_q <= hazard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (lu_stall) state_d = ST_LU_STALL;
      ST_LU_STALL: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_comb begin
    hazard_d = hazard_q | ((state_q == ST_LU_STALL) && lu_stall);
  end

  assign hazard_err = hazard_q;

  // ---------------- statistics ----------------
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [7:0]       b);
    logic [CNT_W+7:0] s;
    s = {8'd0, a} + {{CNT_W{1'b0}}, b};
    if (s[CNT_W+7:CNT_W] != '0) return '1;
    return s[CNT_W-1:0];
  endfunction

  logic [7:0]       src_hits [NSRC];
  logic [CNT_W-1:0] fwd_cnt_q [NSRC];
  logic [CNT_W-1:0] fwd_cnt_d [NSRC];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Number of ports taking each source this cycle; only a decode that
  // actually advances (valid, not stalled) is counted.
  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      src_hits[s] = '0;
      if (d_valid && !lu_stall) begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
          if (port_sel[p] == SRC_IDX_W'(s)) src_hits[s] = src_hits[s] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      fwd_cnt_d[s] = cnt_clr ? '0 : sat_add(fwd_cnt_q[s], src_hits[s]);
    end
    stall_cnt_d = cnt_clr ? '0 : sat_add(stall_cnt_q, {7'd0, lu_stall});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < NSRC; s++) fwd_cnt_q[s] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned s = 0; s < NSRC; s++) fwd_cnt_q[s] <= fwd_cnt_d[s];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_cnt_out
    assign fwd_cnt[s*CNT_W +: CNT_W] = fwd_cnt_q[s];
  end
  assign stall_cnt = stall_cnt_q;

endmodule
